// File: rtl/ex_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ex_ctrl_pkg
// Shared types for the execute-stage hazard controller:
//   state_t    - controller FSM states (RUN, STALL, FLUSH)
//   ex_slot_t  - tracking record for the instruction now in EX
//   mem_slot_t - tracking record for the instruction now in MEM
//   REG_X0     - architectural zero register, never forwarded, never stalls
// ----------------------------------------------------------------------------
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wen;
        logic       load;
    } ex_slot_t;

    // The load flag only matters while the producer is one stage ahead of
    // decode, so the MEM record does not carry it.
    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wen;
    } mem_slot_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage : ex_ctrl_pkg

// File: rtl/ex_hazard_match.sv
// ----------------------------------------------------------------------------
// ex_hazard_match
// Combinational comparator: does a tracked producer slot write the register
// that a decode source operand reads?
// Ports:
//   slot_vld, slot_wen, slot_rd : producer slot contents
//   rs, rs_used                 : decode source register and its use flag
//   hit                         : operand depends on the slot (x0 excluded)
// ----------------------------------------------------------------------------
module ex_hazard_match
    import ex_ctrl_pkg::*;
(
    input  logic       slot_vld,
    input  logic       slot_wen,
    input  logic [4:0] slot_rd,
    input  logic [4:0] rs,
    input  logic       rs_used,
    output logic       hit
);

    // x0 reads are constant zero, so they never depend on a producer.
    always_comb begin
        hit = slot_vld & slot_wen & rs_used & (rs == slot_rd) & (rs != REG_X0);
    end

endmodule : ex_hazard_match

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
// Execute-stage hazard controller. Tracks the EX and MEM destination slots,
// registers operand-forwarding selects at issue, stalls fetch/decode for one
// cycle on a load-use hazard and sequences a FLUSH_DEPTH-cycle flush when EX
// resolves a redirect. Redirect takes priority over load-use.
// Parameters: FLUSH_DEPTH (1..3) flush cycles, CNT_W counter width.
// Ports:
//   i_clk, i_rst_n (synchronous, active low)
//   i_id_*         : decode-stage instruction fields
//   i_ex_redirect  : EX resolved a control transfer
//   o_pc_stall, o_id_stall, o_ex_bubble, o_flush : combinational controls
//   o_frwd_*       : registered forwarding selects for the instruction in EX
//   o_stall_cnt, o_flush_cnt : performance counters
// Build option: define EX_HAZARD_PERF_EN to implement the counters; when
// undefined the counter ports are tied to zero.
// ----------------------------------------------------------------------------
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_vld,
    input  logic [4:0]       i_id_rs1_raddr,
    input  logic [4:0]       i_id_rs2_raddr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd_waddr,
    input  logic             i_id_rd_wen,
    input  logic             i_id_mem_read,
    input  logic             i_ex_redirect,
    output logic             o_pc_stall,
    output logic             o_id_stall,
    output logic             o_ex_bubble,
    output logic             o_flush,
    output logic             o_frwd_alu_op1,
    output logic             o_frwd_mem_op1,
    output logic             o_frwd_alu_op2,
    output logic             o_frwd_mem_op2,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] fcnt;
    logic [1:0] fcnt_nxt;
    ex_slot_t   ex_slot;
    mem_slot_t  mem_slot;

    logic ex_hit1;
    logic ex_hit2;
    logic mem_hit1;
    logic mem_hit2;
    logic flushing;
    logic stall;
    logic bubble;
    logic issue;

    ex_hazard_match u_ex_rs1 (
        .slot_vld (ex_slot.vld), .slot_wen (ex_slot.wen), .slot_rd (ex_slot.rd),
        .rs (i_id_rs1_raddr), .rs_used (i_id_rs1_used), .hit (ex_hit1)
    );
    ex_hazard_match u_ex_rs2 (
        .slot_vld (ex_slot.vld), .slot_wen (ex_slot.wen), .slot_rd (ex_slot.rd),
        .rs (i_id_rs2_raddr), .rs_used (i_id_rs2_used), .hit (ex_hit2)
    );
    ex_hazard_match u_mem_rs1 (
        .slot_vld (mem_slot.vld), .slot_wen (mem_slot.wen), .slot_rd (mem_slot.rd),
        .rs (i_id_rs1_raddr), .rs_used (i_id_rs1_used), .hit (mem_hit1)
    );
    ex_hazard_match u_mem_rs2 (
        .slot_vld (mem_slot.vld), .slot_wen (mem_slot.wen), .slot_rd (mem_slot.rd),
        .rs (i_id_rs2_raddr), .rs_used (i_id_rs2_used), .hit (mem_hit2)
    );

    // Hazard decode and next-state logic; redirect overrides any load-use.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        flushing  = i_ex_redirect | (state == FLUSH);
        stall     = i_id_vld & ex_slot.load & (ex_hit1 | ex_hit2) & ~flushing;
        bubble    = stall | flushing;
        issue     = i_id_vld & ~bubble;
        if (i_ex_redirect) begin
            // The redirect cycle itself is the first flush cycle.
            fcnt_nxt = FLUSH_LOAD;
            if (FLUSH_LOAD == 2'd0) begin
                state_nxt = RUN;
            end else begin
                state_nxt = FLUSH;
            end
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        state_nxt = STALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                STALL: begin
                    state_nxt = RUN;
                end
                FLUSH: begin
                    if (fcnt <= 2'd1) begin
                        state_nxt = RUN;
                        fcnt_nxt  = 2'd0;
                    end else begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = fcnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    fcnt_nxt  = 2'd0;
                end
            endcase
        end
    end

    assign o_pc_stall  = stall;
    assign o_id_stall  = stall;
    assign o_ex_bubble = bubble;
    assign o_flush     = flushing;

    // State, slot tracking and registered forwarding selects.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= RUN;
            fcnt           <= 2'd0;
            ex_slot        <= '0;
            mem_slot       <= '0;
            o_frwd_alu_op1 <= 1'b0;
            o_frwd_mem_op1 <= 1'b0;
            o_frwd_alu_op2 <= 1'b0;
            o_frwd_mem_op2 <= 1'b0;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            mem_slot <= '{vld: ex_slot.vld, rd: ex_slot.rd, wen: ex_slot.wen};
            if (issue) begin
                ex_slot <= '{vld: 1'b1, rd: i_id_rd_waddr, wen: i_id_rd_wen,
                             load: i_id_mem_read};
            end else begin
                ex_slot <= '0;
            end
            // The younger producer (EX) wins over MEM so the two never overlap.
            o_frwd_alu_op1 <= issue & ex_hit1;
            o_frwd_mem_op1 <= issue & ~ex_hit1 & mem_hit1;
            o_frwd_alu_op2 <= issue & ex_hit2;
            o_frwd_mem_op2 <= issue & ~ex_hit2 & mem_hit2;
        end
    end

`ifdef EX_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating counters of load-use stall cycles and accepted redirects.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (i_ex_redirect && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_stall_cnt = {CNT_W{1'b0}};
    assign o_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule : ex_hazard_ctrl
